// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the operands; S2 evaluates, registers result and flags, and drives all outputs.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  // Packs {overflow, carryout, result}; SUB carry is the no-borrow flag.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [2:0]              fop,
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    sum_add = {1'b0, x} + {1'b0, y};
    sum_sub = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    ovf_add = (x[WIDTH-1] == y[WIDTH-1]) && (sum_add[WIDTH-1] != x[WIDTH-1]);
    ovf_sub = (x[WIDTH-1] != y[WIDTH-1]) && (sum_sub[WIDTH-1] != x[WIDTH-1]);
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fop)
      OP_ADD: begin
        res = sum_add[WIDTH-1:0];
        c   = sum_add[WIDTH];
        v   = ovf_add;
      end
      OP_SUB: begin
        res = sum_sub[WIDTH-1:0];
        c   = sum_sub[WIDTH];
        v   = ovf_sub;
      end
      OP_XOR:  res = x ^ y;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
      OP_AND:  res = x & y;
      OP_NAND: res = ~(x & y);
      OP_NOR:  res = ~(x | y);
      OP_OR:   res = x | y;
      default: res = '0;
    endcase
    return {v, c, res};
  endfunction

  logic                    vld_p1;
  logic [2:0]              op_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;

  logic                    vld_p2;
  logic [WIDTH-1:0]        res_p2;
  logic                    cout_p2;
  logic                    ovf_p2;
  logic                    zero_p2;

  logic                    sticky_q;
  logic [CNT_W-1:0]        ops_cnt;

  logic                    s1_adv;
  logic                    s2_adv;
  logic                    accept;
  logic                    deliver;
  logic [WIDTH+1:0]        eval_p1;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv && !reset;
  assign accept   = in_valid && in_ready;
  assign deliver  = vld_p2 && out_ready;
  assign eval_p1  = alu_eval(op_p1, a_p1, b_p1);

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
    end
    if (accept) begin
      op_p1 <= op;
      a_p1  <= a;
      b_p1  <= b;
    end
  end

  // ---- Stage 2: evaluate and register result/flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      res_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2  <= eval_p1[WIDTH-1:0];
        cout_p2 <= eval_p1[WIDTH];
        ovf_p2  <= eval_p1[WIDTH+1];
        zero_p2 <= (eval_p1[WIDTH-1:0] == '0);
      end
    end
  end

  // ---- Delivery bookkeeping: sticky overflow (set beats clear) and beat counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      ops_cnt  <= '0;
    end else begin
      sticky_q <= (sticky_q && !clr_sticky) || (deliver && ovf_p2);
      if (deliver) begin
        ops_cnt <= ops_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = vld_p2;
  assign result     = res_p2;
  assign carryout   = cout_p2;
  assign overflow   = ovf_p2;
  assign zero       = zero_p2;
  assign sticky_ovf = sticky_q;
  assign ops_done   = ops_cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 32-bit and an 8-bit instance driven with directed vectors.
module tb_alu_pipe;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32, c32, v32, z32, st32, clr32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, r32;
  logic [15:0] cnt32;

  logic        iv8, ir8, ov8, or8, c8, v8, z8, st8, clr8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  cnt8;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(32), .CNT_W(16)) u32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .op(op32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .result(r32), .carryout(c32), .overflow(v32), .zero(z32),
    .sticky_ovf(st32), .clr_sticky(clr32), .ops_done(cnt32)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .carryout(c8), .overflow(v8), .zero(z8),
    .sticky_ovf(st8), .clr_sticky(clr8), .ops_done(cnt8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors sample 1 time unit after the falling edge, ahead of the delivering rising edge.
  always @(negedge clk) begin : mon32
    exp_t e;
    #1;
    if (!reset && ov32 && or32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w32 unexpected delivery: got result 0x%0h expected no beat", r32);
      end else begin
        e = q32.pop_front();
        chk("w32 result",   64'(r32), e.res);
        chk("w32 carryout", 64'(c32), 64'(e.c));
        chk("w32 overflow", 64'(v32), 64'(e.v));
        chk("w32 zero",     64'(z32), 64'(e.z));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    #1;
    if (!reset && ov8 && or8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8 unexpected delivery: got result 0x%0h expected no beat", r8);
      end else begin
        e = q8.pop_front();
        chk("w8 result",   64'(r8), e.res);
        chk("w8 carryout", 64'(c8), 64'(e.c));
        chk("w8 overflow", 64'(v8), 64'(e.v));
        chk("w8 zero",     64'(z8), 64'(e.z));
      end
    end
  end

  task automatic send(input bit w8, input logic [2:0] fop, input logic [63:0] fa,
                      input logic [63:0] fb, input logic [63:0] er,
                      input logic ec, input logic ev, input logic ez);
    int   n;
    exp_t e;
    n     = 0;
    e.res = er;
    e.c   = ec;
    e.v   = ev;
    e.z   = ez;
    if (w8) begin
      iv8 = 1'b1; op8 = fop; a8 = fa[7:0]; b8 = fb[7:0];
    end else begin
      iv32 = 1'b1; op32 = fop; a32 = fa[31:0]; b32 = fb[31:0];
    end
    #1;
    while (!(w8 ? ir8 : ir32) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept timeout: got in_ready 0 for %0d cycles expected 1", n);
    end else if (w8) begin
      q8.push_back(e);
    end else begin
      q32.push_back(e);
    end
    @(negedge clk);
    if (w8) iv8 = 1'b0;
    else    iv32 = 1'b0;
  endtask

  task automatic drain(input bit w8);
    int n;
    n = 0;
    while (n < 50 && !(w8 ? (q8.size() == 0 && !ov8) : (q32.size() == 0 && !ov32))) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drain timeout: got %0d beats outstanding expected 0",
               w8 ? q8.size() : q32.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "bench stuck");
  end

  initial begin : main
    exp_t        bp[3];
    logic [2:0]  bop[3];
    logic [31:0] ba[3];
    logic [31:0] bb[3];
    int          idx;
    int          n;
    time         t0;

    reset = 1'b1;
    iv32 = 1'b0; or32 = 1'b1; clr32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    iv8  = 1'b0; or8  = 1'b1; clr8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 64'(ov32), 64'd0);
    chk("rst result",    64'(r32),  64'd0);
    chk("rst carryout",  64'(c32),  64'd0);
    chk("rst overflow",  64'(v32),  64'd0);
    chk("rst zero",      64'(z32),  64'd0);
    chk("rst sticky",    64'(st32), 64'd0);
    chk("rst ops_done",  64'(cnt32), 64'd0);
    chk("rst in_ready",  64'(ir32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(ir32), 64'd1);
    chk("post-rst out_valid", 64'(ov32), 64'd0);
    @(negedge clk);

    // Overflowing ADD, then sticky and counter
    send(0, 3'd0, 64'h7FFFFFFF, 64'h1, 64'h80000000, 1'b0, 1'b1, 1'b0);
    drain(0);
    chk("sticky after ovf", 64'(st32), 64'd1);
    chk("ops_done 1", 64'(cnt32), 64'd1);

    send(0, 3'd1, 64'h5, 64'h5, 64'h0, 1'b1, 1'b0, 1'b1);
    send(0, 3'd3, 64'hFFFFFFFF, 64'h1, 64'h1, 1'b0, 1'b0, 1'b0);

    // Logic sweep, one accept per cycle
    t0 = $time;
    send(0, 3'd2, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    send(0, 3'd4, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 1'b0, 1'b0, 1'b0);
    send(0, 3'd5, 64'hF0F0F0F0, 64'hFF00FF00, 64'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
    send(0, 3'd6, 64'hF0F0F0F0, 64'hFF00FF00, 64'h000F000F, 1'b0, 1'b0, 1'b0);
    send(0, 3'd7, 64'hF0F0F0F0, 64'hFF00FF00, 64'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    chk("sweep cycles", 64'(($time - t0) / 10), 64'd5);
    drain(0);
    chk("ops_done 8", 64'(cnt32), 64'd8);

    // Back-pressure: three beats offered against a stalled consumer
    bop[0] = 3'd0; ba[0] = 32'h1;  bb[0] = 32'h2;
    bp[0].res = 64'h3;  bp[0].c = 1'b0; bp[0].v = 1'b0; bp[0].z = 1'b0;
    bop[1] = 3'd1; ba[1] = 32'hA;  bb[1] = 32'h3;
    bp[1].res = 64'h7;  bp[1].c = 1'b1; bp[1].v = 1'b0; bp[1].z = 1'b0;
    bop[2] = 3'd7; ba[2] = 32'h0F; bb[2] = 32'hF0;
    bp[2].res = 64'hFF; bp[2].c = 1'b0; bp[2].v = 1'b0; bp[2].z = 1'b0;
    or32 = 1'b0;
    idx  = 0;
    iv32 = 1'b1; op32 = bop[0]; a32 = ba[0]; b32 = bb[0];
    for (int k = 0; k < 6; k++) begin
      #1;
      if (ir32 && idx < 3) begin
        q32.push_back(bp[idx]);
        idx++;
      end
      @(negedge clk);
      if (idx < 3) begin
        op32 = bop[idx]; a32 = ba[idx]; b32 = bb[idx];
      end else begin
        iv32 = 1'b0;
      end
    end
    #1;
    chk("bp accepted", 64'(idx), 64'd2);
    chk("bp in_ready", 64'(ir32), 64'd0);
    chk("bp out_valid", 64'(ov32), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("bp held result", 64'(r32), 64'h3);
    chk("bp held out_valid", 64'(ov32), 64'd1);
    @(negedge clk);
    or32 = 1'b1;
    #1;
    chk("bp in_ready comb", 64'(ir32), 64'd1);
    q32.push_back(bp[2]);
    @(negedge clk);
    iv32 = 1'b0;
    drain(0);
    chk("ops_done 11", 64'(cnt32), 64'd11);

    // Clear and set of sticky in the same cycle: set wins
    clr32 = 1'b1;
    @(negedge clk);
    clr32 = 1'b0;
    #1;
    chk("sticky cleared", 64'(st32), 64'd0);
    @(negedge clk);
    send(0, 3'd0, 64'h7FFFFFFF, 64'h7FFFFFFF, 64'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    n = 0;
    #1;
    while (!ov32 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ovf beat presented", 64'(ov32), 64'd1);
    clr32 = 1'b1;
    @(negedge clk);
    #1;
    chk("sticky set wins", 64'(st32), 64'd1);
    @(negedge clk);
    #1;
    chk("sticky clear alone", 64'(st32), 64'd0);
    clr32 = 1'b0;
    chk("ops_done 12", 64'(cnt32), 64'd12);
    @(negedge clk);

    // 8-bit instance: carry out of the top, then counter wrap
    send(1, 3'd0, 64'hFF, 64'h01, 64'h00, 1'b1, 1'b0, 1'b1);
    drain(1);
    chk("w8 ops_done 1", 64'(cnt8), 64'd1);
    for (int i = 1; i < 16; i++) begin
      send(1, 3'd7, 64'(i), 64'h0, 64'(i), 1'b0, 1'b0, 1'b0);
    end
    drain(1);
    chk("w8 ops_done wrap", 64'(cnt8), 64'd0);

    // Reset with two beats in flight discards them
    or8 = 1'b0;
    send(1, 3'd0, 64'h1, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0);
    send(1, 3'd0, 64'h2, 64'h2, 64'h4, 1'b0, 1'b0, 1'b0);
    #1;
    chk("w8 full before reset", 64'(ir8), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    q8.delete();
    @(negedge clk);
    #1;
    chk("w8 out_valid in reset", 64'(ov8), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    or8   = 1'b1;
    #1;
    chk("w8 out_valid after reset", 64'(ov8), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("w8 no stale delivery", 64'(ov8), 64'd0);
    end
    chk("w8 ops_done after reset", 64'(cnt8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
